// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// trap_ctrl : machine-mode trap/mret CSR write sequencer with PC redirect.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets).
// Revision  : 1.0
// ============================================================================
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exception_v_i,
  input  logic [XLEN-1:0] exception_cause_i,
  input  logic [XLEN-1:0] exception_pc_i,
  input  logic [XLEN-1:0] exception_tval_i,
  input  logic            mret_v_i,
  output logic            csr_write_v_o,
  output logic [11:0]     csr_adr_write_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic [11:0]     csr_adr_read_o,
  input  logic [XLEN-1:0] csr_data_i,
  output logic            busy_o,
  output logic            redirect_v_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    W_MEPC        = 3'd1,
    W_MCAUSE      = 3'd2,
    W_MTVAL       = 3'd3,
    W_MSTATUS     = 3'd4,
    REDIR_TRAP    = 3'd5,
    W_MSTATUS_RET = 3'd6,
    REDIR_RET     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_ret;
  logic [XLEN-1:0] direct_base;
  logic [XLEN-1:0] trap_target;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      busy_q  <= busy_d;
    end
  end

  // Exception has priority over a same-cycle mret; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    case (state_q)
      IDLE: begin
        if (exception_v_i) begin
          state_d = W_MEPC;
          pc_d    = exception_pc_i;
          cause_d = exception_cause_i;
          tval_d  = exception_tval_i;
        end else if (mret_v_i) begin
          state_d = W_MSTATUS_RET;
        end
      end
      W_MEPC:        state_d = W_MCAUSE;
      W_MCAUSE:      state_d = W_MTVAL;
      W_MTVAL:       state_d = W_MSTATUS;
      W_MSTATUS:     state_d = REDIR_TRAP;
      REDIR_TRAP:    state_d = IDLE;
      W_MSTATUS_RET: state_d = REDIR_RET;
      REDIR_RET:     state_d = IDLE;
      default:       state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    mstatus_trap        = csr_data_i;
    mstatus_trap[7]     = csr_data_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_ret         = csr_data_i;
    mstatus_ret[3]      = csr_data_i[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b11;
  end

  assign direct_base = {csr_data_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode only applies to interrupts; the offset wraps modulo 2^XLEN.
  always_comb begin
    trap_target = direct_base;
    if ((csr_data_i[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      trap_target = direct_base + ({1'b0, cause_q[XLEN-2:0]} << 2);
    end
  end
`else
  assign trap_target = direct_base;
`endif

  always_comb begin
    csr_write_v_o   = 1'b0;
    csr_adr_write_o = '0;
    csr_data_o      = '0;
    csr_adr_read_o  = '0;
    redirect_v_o    = 1'b0;
    redirect_pc_o   = '0;
    case (state_q)
      W_MEPC: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MEPC;
        csr_data_o      = pc_q;
      end
      W_MCAUSE: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MCAUSE;
        csr_data_o      = cause_q;
      end
      W_MTVAL: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MTVAL;
        csr_data_o      = tval_q;
      end
      W_MSTATUS: begin
        csr_adr_read_o  = CSR_MSTATUS;
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MSTATUS;
        csr_data_o      = mstatus_trap;
      end
      REDIR_TRAP: begin
        csr_adr_read_o  = CSR_MTVEC;
        redirect_v_o    = 1'b1;
        redirect_pc_o   = trap_target;
      end
      W_MSTATUS_RET: begin
        csr_adr_read_o  = CSR_MSTATUS;
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MSTATUS;
        csr_data_o      = mstatus_ret;
      end
      REDIR_RET: begin
        csr_adr_read_o  = CSR_MEPC;
        redirect_v_o    = 1'b1;
        redirect_pc_o   = direct_base;
      end
      default: ;
    endcase
  end

  assign busy_o = busy_q;

endmodule
`default_nettype wire
